// File: rtl/apb_xbar.sv
// apb_xbar -- APB3 one-to-N interconnect.
//
// Decodes each upstream transfer against per-slave address windows
// (base inclusive, limit exclusive, unsigned, lowest index wins on overlap)
// and re-launches it as a registered SETUP/ACCESS sequence on exactly one
// downstream slave. Unmapped addresses are answered by an internal default
// slave with an error response.
//
// Optional feature macro: APB_XBAR_TIMEOUT_EN
//   When defined, an ACCESS phase that sees no ready for TIMEOUT_CYC
//   consecutive cycles is abandoned and answered with an error.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   s_psel/s_penable/s_pwrite       upstream APB control
//   s_paddr, s_pwdata               upstream address / write data
//   s_pready, s_prdata, s_pslverr   upstream response
//   m_psel, m_penable               per-slave select / enable (one-hot)
//   m_paddr, m_pwrite, m_pwdata     registered request, shared by all slaves
//   m_pready, m_prdata, m_pslverr   per-slave response (slave i at [i*DW +: DW])
module apb_xbar #(
  parameter int unsigned N_SLV = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE =
    {32'hC000_1000, 32'h0000_0000, 32'hA000_0000, 32'h8000_0000},
  parameter logic [N_SLV*AW-1:0] SLV_LIMIT =
    {32'hC000_FFFF, 32'h1000_0000, 32'hC000_0000, 32'hA000_0000},
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_psel,
  input  logic                s_penable,
  input  logic                s_pwrite,
  input  logic [AW-1:0]       s_paddr,
  input  logic [DW-1:0]       s_pwdata,
  output logic                s_pready,
  output logic [DW-1:0]       s_prdata,
  output logic                s_pslverr,
  output logic [N_SLV-1:0]    m_psel,
  output logic [N_SLV-1:0]    m_penable,
  output logic [AW-1:0]       m_paddr,
  output logic                m_pwrite,
  output logic [DW-1:0]       m_pwdata,
  input  logic [N_SLV-1:0]    m_pready,
  input  logic [N_SLV*DW-1:0] m_prdata,
  input  logic [N_SLV-1:0]    m_pslverr
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

  state_t            state, state_nxt;
  logic              start;
  logic              dec_hit;
  logic [N_SLV-1:0]  dec_oh;
  // Selected slave kept one-hot so the response mux and the select outputs
  // need no index arithmetic (also keeps N_SLV=1 free of zero-width indices).
  logic [N_SLV-1:0]  sel_oh;
  logic              sel_ready;
  logic              sel_err;
  logic [DW-1:0]     sel_rdata;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              timeout;

  // A new transfer is accepted only on a proper upstream SETUP phase;
  // psel with penable already high in IDLE is a protocol violation.
  assign start = s_psel && !s_penable;

  // Address decode: first matching window in ascending index order wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_oh  = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!dec_hit &&
          (s_paddr >= SLV_BASE[i*AW +: AW]) &&
          (s_paddr <  SLV_LIMIT[i*AW +: AW])) begin
        dec_hit   = 1'b1;
        dec_oh[i] = 1'b1;
      end
    end
  end

  // Response mux from the selected slave.
  assign sel_ready = |(m_pready & sel_oh);
  assign sel_err   = |(m_pslverr & sel_oh);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (sel_oh[i]) begin
        sel_rdata = sel_rdata | m_prdata[i*DW +: DW];
      end
    end
  end

`ifdef APB_XBAR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;

  // ACCESS is only ever entered from SETUP, so clearing in SETUP is
  // equivalent to clearing on ACCESS entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !sel_ready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires at the end of the TIMEOUT_CYC-th ready-less ACCESS cycle; a ready
  // arriving in that same cycle takes precedence.
  assign timeout = (state == ACCESS) && !sel_ready &&
                   (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = dec_hit ? SETUP : ERR;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_paddr   <= '0;
      m_pwrite  <= 1'b0;
      m_pwdata  <= '0;
      sel_oh    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        m_paddr  <= s_paddr;
        m_pwrite <= s_pwrite;
        m_pwdata <= s_pwdata;
        sel_oh   <= dec_oh;
      end
      if (state == ACCESS) begin
        if (sel_ready) begin
          rsp_rdata <= sel_rdata;
          rsp_err   <= sel_err;
        end else if (timeout) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    m_psel    = '0;
    m_penable = '0;
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    case (state)
      SETUP: begin
        m_psel = sel_oh;
      end
      ACCESS: begin
        m_psel    = sel_oh;
        m_penable = sel_oh;
      end
      RESP: begin
        s_pready  = 1'b1;
        s_pslverr = rsp_err;
        s_prdata  = rsp_rdata;
      end
      ERR: begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_xbar.sv
// tb_apb_xbar -- self-checking bench for apb_xbar with default windows.
// The bench plays both the upstream requester and all downstream slaves;
// expected behaviour comes from a window table and a cycle timeline model.
module tb_apb_xbar;

  localparam int N = 4;
  localparam int TO_CYC = 4;
`ifdef APB_XBAR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_psel, s_penable, s_pwrite;
  logic [31:0]   s_paddr, s_pwdata;
  logic          s_pready, s_pslverr;
  logic [31:0]   s_prdata;
  logic [N-1:0]  m_psel, m_penable;
  logic [31:0]   m_paddr, m_pwdata;
  logic          m_pwrite;
  logic [N-1:0]  m_pready, m_pslverr;
  logic [N*32-1:0] m_prdata;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  logic [31:0] win_base [N] = '{32'h8000_0000, 32'hA000_0000, 32'h0000_0000, 32'hC000_1000};
  logic [31:0] win_lim  [N] = '{32'hA000_0000, 32'hC000_0000, 32'h1000_0000, 32'hC000_FFFF};

  apb_xbar #(.N_SLV(N), .AW(32), .DW(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (a >= win_base[i] && a < win_lim[i]) return i;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_psel"}, 32'(m_psel), 32'h0);
    chk({tag, "_penable"}, 32'(m_penable), 32'h0);
    chk({tag, "_paddr"}, m_paddr, 32'h0);
    chk({tag, "_pwrite"}, 32'(m_pwrite), 32'h0);
    chk({tag, "_pwdata"}, m_pwdata, 32'h0);
    chk({tag, "_pready"}, 32'(s_pready), 32'h0);
    chk({tag, "_prdata"}, s_prdata, 32'h0);
    chk({tag, "_pslverr"}, 32'(s_pslverr), 32'h0);
  endtask

  // Slaves other than the addressed one present random responses.
  task automatic noise_slaves();
    for (int j = 0; j < N; j++) m_prdata[j*32 +: 32] = $urandom;
    m_pready  = N'($urandom);
    m_pslverr = N'($urandom);
  endtask

  // One upstream transfer starting in the current cycle (called just after
  // a rising edge). w = wait cycles of the addressed slave; drop = requester
  // abandons the transfer after its ACCESS phase begins.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input int w, input logic [31:0] rd, input logic se, input bit drop);
    int idx, resp_k;
    logic [N-1:0] oh, e_psel, e_pen;
    logic [31:0] exp_rd;
    logic exp_err, timed;
    idx = decode(a);
    oh = (idx >= 0) ? N'(1 << idx) : '0;
    timed = TO_EN && (idx >= 0) && (w >= TO_CYC);
    if (idx < 0) resp_k = 1;
    else if (timed) resp_k = 2 + TO_CYC;
    else resp_k = 3 + w;
    exp_rd  = (idx < 0 || timed) ? 32'h0 : rd;
    exp_err = (idx < 0 || timed) ? 1'b1 : se;
    for (int k = 0; k <= resp_k; k++) begin
      s_psel = 1'b1; s_penable = (k > 0);
      if (drop && k >= 2) begin s_psel = 1'b0; s_penable = 1'b0; end
      s_paddr = a; s_pwrite = wr; s_pwdata = wd;
      noise_slaves();
      if (idx >= 0) begin
        m_prdata[idx*32 +: 32] = rd;
        m_pslverr[idx] = se;
        m_pready[idx]  = (k >= 2 + w);
      end
      @(negedge clk);
      e_psel = (idx >= 0 && k >= 1 && k < resp_k) ? oh : '0;
      e_pen  = (idx >= 0 && k >= 2 && k < resp_k) ? oh : '0;
      if (k >= 1) begin
        chk("m_psel", 32'(m_psel), 32'(e_psel));
        chk("m_penable", 32'(m_penable), 32'(e_pen));
        chk("m_paddr", m_paddr, a);
        chk("m_pwrite", 32'(m_pwrite), 32'(wr));
        chk("m_pwdata", m_pwdata, wd);
      end
      chk("s_pready", 32'(s_pready), 32'(k == resp_k));
      chk("s_pslverr", 32'(s_pslverr), (k == resp_k) ? 32'(exp_err) : 32'h0);
      chk("s_prdata", s_prdata, (k == resp_k) ? exp_rd : 32'h0);
      @(posedge clk); #1;
    end
  endtask

  // Idle cycles; with viol set the requester presents psel+penable without a
  // SETUP phase, which must be ignored. Last cycle always drives psel low.
  task automatic idle(input int n, input bit viol);
    for (int k = 0; k < n; k++) begin
      s_psel = viol && (k < n - 1); s_penable = s_psel;
      s_paddr = 32'h8000_0040;
      noise_slaves();
      @(negedge clk);
      chk("idle_psel", 32'(m_psel), 32'h0);
      chk("idle_penable", 32'(m_penable), 32'h0);
      chk("idle_pready", 32'(s_pready), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r, j;
    logic [31:0] span;
    r = $urandom_range(0, 5);
    if (r < 4) begin
      span = win_lim[r] - win_base[r];
      return win_base[r] + $urandom_range(0, span - 1);
    end
    if (r == 4) return $urandom;
    j = $urandom_range(0, N - 1);
    return ($urandom_range(0, 1) == 1) ? win_lim[j] : win_base[j] - 32'd1;
  endfunction

  initial begin
    rst = 1'b1;
    s_psel = 0; s_penable = 0; s_pwrite = 0; s_paddr = '0; s_pwdata = '0;
    m_pready = '0; m_prdata = '0; m_pslverr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    xfer(32'h8000_0010, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xfer(32'hC000_2000, 1'b1, 32'h1234_5678, 3, 32'h5555_AAAA, 1'b0, 1'b0);
    xfer(32'h5000_0000, 1'b0, 32'h0, 0, 32'h1111_1111, 1'b0, 1'b0);
    xfer(32'h9FFF_FFFC, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
    xfer(32'hA000_0000, 1'b1, 32'hCAFE_0001, 0, 32'h2222_3333, 1'b0, 1'b0);
    xfer(32'hC000_FFFF, 1'b0, 32'h0, 0, 32'h4444_4444, 1'b0, 1'b0);
    xfer(32'hA000_0100, 1'b0, 32'h0, 1, 32'h7777_8888, 1'b1, 1'b0);
    xfer(32'h0000_0004, 1'b0, 32'h0, 2, 32'h0123_4567, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Reset in the middle of an ACCESS phase.
    s_psel = 1; s_penable = 0; s_paddr = 32'h8000_0020; s_pwrite = 1; s_pwdata = 32'hFFFF_0000;
    m_pready = '0;
    @(posedge clk); #1;
    s_penable = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_penable", 32'(m_penable), 32'h1);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    s_psel = 0; s_penable = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(32'h8000_0010, 1'b0, 32'h0, 0, 32'h600D_600D, 1'b0, 1'b0);

    if (TO_EN) begin
      xfer(32'h0000_1000, 1'b0, 32'h0, 10, 32'h9999_9999, 1'b0, 1'b0);
      xfer(32'h0000_1000, 1'b0, 32'h0, TO_CYC - 1, 32'h8888_1234, 1'b0, 1'b0);
    end

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      xfer(rand_addr(), 1'($urandom), $urandom, $urandom_range(0, 5), $urandom,
           1'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
